// File: rtl/mem_io_responder_pkg.sv
// Shared constants, region-decode enum and address decoder for the
// CPU memory/IO responder.
package mem_io_pkg;

   localparam logic [17:0] IO_UART_ADDR     = 18'h30000;
   localparam logic [17:0] IO_CLK_ADDR      = 18'h30004;
   localparam logic [1:0]  IO_SEL           = 2'b11;
   localparam int unsigned RX_DEPTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_UART,
      REG_CLK,
      REG_NONE
   } region_e;

   // Everything outside the IO window is RAM; inside it only the UART byte
   // and the four counter bytes are live, the rest reads as zero.
   function automatic region_e decode_region(input logic [17:0] addr);
      if (addr[17:16] != IO_SEL) begin
         return REG_RAM;
      end
      if (addr == IO_UART_ADDR) begin
         return REG_UART;
      end
      if (addr[17:2] == IO_CLK_ADDR[17:2]) begin
         return REG_CLK;
      end
      return REG_NONE;
   endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus host RX/TX byte streams between the CPU/host side
// (master) and the memory/IO responder (slave).
interface mem_io_responder_if;

   logic [31:0] cpu_a;
   logic        cpu_wr;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        cpu_rdy;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        halt;

   modport master (
      output cpu_a, cpu_wr, cpu_dout, rx_valid, rx_data, tx_ready,
      input  cpu_din, cpu_rdy, rx_ready, tx_valid, tx_data, halt
   );

   modport slave (
      input  cpu_a, cpu_wr, cpu_dout, rx_valid, rx_data, tx_ready,
      output cpu_din, cpu_rdy, rx_ready, tx_valid, tx_data, halt
   );

endinterface

// File: rtl/mem_io_responder_rx_fifo.sv
// Synchronous byte FIFO buffering host input until the CPU reads it.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module io_rx_fifo
   import mem_io_pkg::*;
#(
   parameter int unsigned DEPTH = RX_DEPTH_DEFAULT
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output logic [7:0] head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [7:0]     mem_q [DEPTH];
   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic           do_push;
   logic           do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      head     = mem_q[rd_ptr_q[PTR_W-1:0]];
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk_in) begin
      if (!rst_in && do_push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte bus: RAM, UART RX/TX window, cycle counter
// and program-stop. Define MEM_IO_COUNT_STALL_EN to freeze the counter on stalls.
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned RX_DEPTH = RX_DEPTH_DEFAULT
) (
   input logic                clk_in,
   input logic                rst_in,
   mem_io_responder_if.slave  bus
);

   localparam int unsigned RAM_BYTES = 1 << ADDR_W;

   logic [7:0]        ram_q [RAM_BYTES];
   logic [ADDR_W-1:0] ram_idx;
   logic [17:0]       addr;
   region_e           region;

   logic [7:0]  cpu_din_q, cpu_din_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        halt_q, halt_d;
   logic [31:0] counter_q, counter_d;
   logic [31:0] snapshot_q, snapshot_d;

   logic       cpu_rdy;
   logic       accept;
   logic       tx_load_req;
   logic       tx_drain;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_head;
   logic       unused_upper_addr;

   assign unused_upper_addr = ^bus.cpu_a[31:18];
   assign ram_idx           = bus.cpu_a[ADDR_W-1:0];

   io_rx_fifo #(
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (bus.rx_valid),
      .push_data (bus.rx_data),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // Decode and the combinational ready: a stopped program, an empty RX
   // FIFO on a UART read, or a busy TX register on a load all freeze the CPU.
   always_comb begin
      addr        = bus.cpu_a[17:0];
      region      = decode_region(addr);
      tx_load_req = bus.cpu_wr &&
                    (((region == REG_UART) && (bus.cpu_dout != 8'h00)) ||
                     (addr == IO_CLK_ADDR));
      tx_drain    = tx_valid_q && bus.tx_ready;
      cpu_rdy     = 1'b1;
      if (halt_q && !tx_valid_q) begin
         cpu_rdy = 1'b0;
      end else if (!bus.cpu_wr && (region == REG_UART) && fifo_empty) begin
         cpu_rdy = 1'b0;
      end else if (tx_load_req && tx_valid_q && !bus.tx_ready) begin
         cpu_rdy = 1'b0;
      end
      accept   = cpu_rdy && !rst_in;
      fifo_pop = accept && !bus.cpu_wr && (region == REG_UART);
   end

   always_comb begin
      cpu_din_d  = cpu_din_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      halt_d     = halt_q;
      snapshot_d = snapshot_q;
      counter_d  = counter_q + 32'd1;
`ifdef MEM_IO_COUNT_STALL_EN
      if (!cpu_rdy) begin
         counter_d = counter_q;
      end
`endif
      if (tx_drain) begin
         tx_valid_d = 1'b0;
      end
      if (accept && !bus.cpu_wr) begin
         unique case (region)
            REG_RAM:  cpu_din_d = ram_q[ram_idx];
            REG_UART: cpu_din_d = fifo_head;
            REG_CLK: begin
               // Byte 0 captures the live counter so the upper bytes read coherently.
               if (addr[1:0] == 2'b00) begin
                  snapshot_d = counter_q;
                  cpu_din_d  = counter_q[7:0];
               end else begin
                  cpu_din_d  = snapshot_q[{addr[1:0], 3'b000} +: 8];
               end
            end
            default:  cpu_din_d = 8'h00;
         endcase
      end
      if (accept && tx_load_req) begin
         tx_valid_d = 1'b1;
         tx_data_d  = (region == REG_UART) ? bus.cpu_dout : 8'h00;
         if (region == REG_CLK) begin
            halt_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cpu_din_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         halt_q     <= 1'b0;
         counter_q  <= 32'h0;
         snapshot_q <= 32'h0;
      end else begin
         cpu_din_q  <= cpu_din_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         halt_q     <= halt_d;
         counter_q  <= counter_d;
         snapshot_q <= snapshot_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (accept && bus.cpu_wr && (region == REG_RAM)) begin
         ram_q[ram_idx] <= bus.cpu_dout;
      end
   end

   assign bus.cpu_din  = cpu_din_q;
   assign bus.cpu_rdy  = cpu_rdy;
   assign bus.rx_ready = !fifo_full;
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.halt     = halt_q;

endmodule
